// File: rtl/tc_pll_ctrl_if.sv
// -----------------------------------------------------------------------------
// tc_pll_ctrl_if
//
// Configuration channel into the PLL sequencer. A valid/ready handshake
// carries one complete divider/bypass set per transfer.
//
//   cfg_valid    master -> slave  new configuration offered (held until taken)
//   cfg_ready    slave  -> master configuration accepted this cycle if valid
//   cfg_refdiv   master -> slave  reference divider
//   cfg_fbdiv    master -> slave  feedback divider
//   cfg_postdiv1 master -> slave  post-divider 1
//   cfg_postdiv2 master -> slave  post-divider 2
//   cfg_bp       master -> slave  bypass request
// -----------------------------------------------------------------------------
interface tc_pll_ctrl_if #(
  parameter int unsigned REFDIV_W = 8,
  parameter int unsigned FBDIV_W  = 12,
  parameter int unsigned PD1_W    = 4,
  parameter int unsigned PD2_W    = 2
);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [REFDIV_W-1:0] cfg_refdiv;
  logic [FBDIV_W-1:0]  cfg_fbdiv;
  logic [PD1_W-1:0]    cfg_postdiv1;
  logic [PD2_W-1:0]    cfg_postdiv2;
  logic                cfg_bp;

  modport master (
    output cfg_valid,
    output cfg_refdiv,
    output cfg_fbdiv,
    output cfg_postdiv1,
    output cfg_postdiv2,
    output cfg_bp,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_refdiv,
    input  cfg_fbdiv,
    input  cfg_postdiv1,
    input  cfg_postdiv2,
    input  cfg_bp,
    output cfg_ready
  );

endinterface

// File: rtl/tc_pll_ctrl.sv
// -----------------------------------------------------------------------------
// tc_pll_ctrl
//
// PLL configuration and lock sequencer. Owns the divider/bypass registers of
// the PLL macro, holds the macro in reset for RST_CYCLES, waits at least
// LOCK_CNT_END+1 cycles for lock (optionally also for the synchronised lock
// detect), and re-runs the sequence on every accepted reconfiguration or on
// loss of lock. lock_o is never high while the dividers are being changed.
//
// Ports
//   clk_i           reference clock; every flop lives in this domain
//   rst_i           asynchronous, active-high reset
//   cfg             configuration channel (slave side of tc_pll_ctrl_if)
//   lkdt_i          macro lock detect, asynchronous to clk_i
//   pll_rst_o       macro reset (also held high in bypass to power it down)
//   pll_refdiv_o    registered reference divider
//   pll_fbdiv_o     registered feedback divider
//   pll_postdiv1_o  registered post-divider 1
//   pll_postdiv2_o  registered post-divider 2
//   pll_bp_o        registered bypass
//   lock_o          output clock valid (LOCK or BYP)
//   state_o         current state: HOLD=0, WAIT=1, LOCK=2, BYP=3
//   relock_cnt_o    saturating count of lock-loss events
//
// All outputs come straight from flops; nothing combinational reaches a port.
// -----------------------------------------------------------------------------
module tc_pll_ctrl #(
  parameter int unsigned           REFDIV_W     = 8,
  parameter int unsigned           FBDIV_W      = 12,
  parameter int unsigned           PD1_W        = 4,
  parameter int unsigned           PD2_W        = 2,
  parameter int unsigned           RST_CYCLES   = 16,
  parameter int unsigned           LOCK_CNT_W   = 20,
  parameter logic [LOCK_CNT_W-1:0] LOCK_CNT_END = 20'h1FFFF,
  parameter bit                    USE_LKDT     = 1'b1,
  parameter logic [REFDIV_W-1:0]   DEF_REFDIV   = REFDIV_W'(1),
  parameter logic [FBDIV_W-1:0]    DEF_FBDIV    = FBDIV_W'(1),
  parameter logic [PD1_W-1:0]      DEF_PD1      = PD1_W'(1),
  parameter logic [PD2_W-1:0]      DEF_PD2      = PD2_W'(1),
  parameter logic                  DEF_BP       = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  tc_pll_ctrl_if.slave        cfg,
  input  logic                lkdt_i,
  output logic                pll_rst_o,
  output logic [REFDIV_W-1:0] pll_refdiv_o,
  output logic [FBDIV_W-1:0]  pll_fbdiv_o,
  output logic [PD1_W-1:0]    pll_postdiv1_o,
  output logic [PD2_W-1:0]    pll_postdiv2_o,
  output logic                pll_bp_o,
  output logic                lock_o,
  output logic [1:0]          state_o,
  output logic [7:0]          relock_cnt_o
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOCK = 2'd2,
    ST_BYP  = 2'd3
  } state_e;

  // hold_cnt only has to reach RST_CYCLES-1.
  localparam int unsigned        HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [7:0]         RELOCK_MAX = 8'hFF;

  // ---------------------------------------------------------------------------
  // Lock-detect synchroniser
  // ---------------------------------------------------------------------------
  // lkdt_i comes from the macro's own clock domain; two flops bring it into
  // clk_i before any decision is taken on it.
  logic [1:0] lkdt_sync_q;
  logic       lkdt_s;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lkdt_sync_q <= 2'b00;
    end else begin
      lkdt_sync_q <= {lkdt_sync_q[0], lkdt_i};
    end
  end

  assign lkdt_s = lkdt_sync_q[1];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_e                state_q,      state_d;
  logic [HOLD_W-1:0]     hold_cnt_q,   hold_cnt_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
  logic [7:0]            relock_q,     relock_d;
  logic                  cfg_ready_q;
  logic                  accept;
  logic                  lkdt_ok;
  logic                  lkdt_lost;
  logic                  lock_d;
  logic                  ready_d;
  logic                  pll_rst_d;

  // cfg_ready is a registered copy of "state is LOCK or BYP", so an accept can
  // only happen in those two states.
  assign accept    = cfg.cfg_valid & cfg_ready_q;
  assign lkdt_ok   = !USE_LKDT || lkdt_s;
  assign lkdt_lost = USE_LKDT && !lkdt_s;

  // NOTE: every variable written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lock_cnt_d = lock_cnt_q;
    relock_d   = relock_q;

    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          // The bypass register has already been updated by the accept that
          // brought us here, so this picks the newly requested mode.
          state_d    = pll_bp_o ? ST_BYP : ST_WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (lock_cnt_q != LOCK_CNT_END) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        // Minimum wait elapsed; with lock detect in use, stay here as long as
        // the macro does not report lock.
        if ((lock_cnt_q == LOCK_CNT_END) && lkdt_ok) begin
          lock_cnt_d = '0;
          state_d    = ST_LOCK;
        end
      end

      ST_LOCK: begin
        // A reconfiguration wins over a coincident lock loss and is not
        // counted as a relock event.
        if (accept) begin
          state_d = ST_HOLD;
        end else if (lkdt_lost) begin
          state_d = ST_HOLD;
          if (relock_q != RELOCK_MAX) begin
            relock_d = relock_q + 8'd1;
          end
        end
      end

      ST_BYP: begin
        // Macro is powered down: lock detect is meaningless here.
        if (accept) begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Port-level flags are registered alongside the state so they change on
    // the same edge as state_o.
    lock_d    = (state_d == ST_LOCK) || (state_d == ST_BYP);
    ready_d   = lock_d;
    pll_rst_d = (state_d == ST_HOLD) || (state_d == ST_BYP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      relock_q    <= '0;
      cfg_ready_q <= 1'b0;
      lock_o      <= 1'b0;
      pll_rst_o   <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      relock_q    <= relock_d;
      cfg_ready_q <= ready_d;
      lock_o      <= lock_d;
      pll_rst_o   <= pll_rst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Divider / bypass registers
  // ---------------------------------------------------------------------------
  // Loaded only on accept, which always sends the state to HOLD on the same
  // edge, so the macro sees new dividers only while it is held in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pll_refdiv_o   <= DEF_REFDIV;
      pll_fbdiv_o    <= DEF_FBDIV;
      pll_postdiv1_o <= DEF_PD1;
      pll_postdiv2_o <= DEF_PD2;
      pll_bp_o       <= DEF_BP;
    end else if (accept) begin
      pll_refdiv_o   <= cfg.cfg_refdiv;
      pll_fbdiv_o    <= cfg.cfg_fbdiv;
      pll_postdiv1_o <= cfg.cfg_postdiv1;
      pll_postdiv2_o <= cfg.cfg_postdiv2;
      pll_bp_o       <= cfg.cfg_bp;
    end
  end

  // ---------------------------------------------------------------------------
  // Output assignments
  // ---------------------------------------------------------------------------
  assign cfg.cfg_ready = cfg_ready_q;
  assign state_o       = state_q;
  assign relock_cnt_o  = relock_q;

endmodule

// File: tb/tb_tc_pll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tc_pll_ctrl
//
// Directed bench for tc_pll_ctrl with RST_CYCLES=4, LOCK_CNT_END=10,
// USE_LKDT=1, DEF_BP=0. Stimulus pushes hand-computed expectations (output
// snapshots at given cycles, and lock_o transitions) into queues; a monitor on
// the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_tc_pll_ctrl;

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;
  localparam logic [1:0] S_BYP  = 2'd3;

  typedef struct packed {
    logic [7:0]  rd;
    logic [11:0] fb;
    logic [3:0]  p1;
    logic [1:0]  p2;
    logic        bp;
  } cfg_t;

  typedef struct packed {
    logic       rst;
    logic       lock;
    logic       rdy;
    logic [1:0] st;
    logic [7:0] rc;
    cfg_t       cfg;
  } obs_t;

  typedef struct {
    int    cyc;
    string nm;
    obs_t  v;
  } snap_t;

  typedef struct {
    int   cyc;
    logic val;
  } edge_t;

  localparam cfg_t DEF_CFG = '{rd: 8'd1,  fb: 12'd1,   p1: 4'd1, p2: 2'd1, bp: 1'b0};
  localparam cfg_t D_CFG   = '{rd: 8'd3,  fb: 12'd100, p1: 4'd2, p2: 2'd1, bp: 1'b0};
  localparam cfg_t DECOY   = '{rd: 8'd7,  fb: 12'd200, p1: 4'd9, p2: 2'd3, bp: 1'b1};
  localparam cfg_t E_CFG   = '{rd: 8'h12, fb: 12'hABC, p1: 4'h5, p2: 2'h2, bp: 1'b1};
  localparam cfg_t F_CFG   = '{rd: 8'd5,  fb: 12'h040, p1: 4'd3, p2: 2'd0, bp: 1'b0};

  logic        clk = 1'b0;
  logic        rst_i;
  logic        lkdt_i;
  logic        pll_rst_o;
  logic [7:0]  pll_refdiv_o;
  logic [11:0] pll_fbdiv_o;
  logic [3:0]  pll_postdiv1_o;
  logic [1:0]  pll_postdiv2_o;
  logic        pll_bp_o;
  logic        lock_o;
  logic [1:0]  state_o;
  logic [7:0]  relock_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit drain  = 1'b0;

  snap_t snap_q[$];
  edge_t edge_q[$];

  tc_pll_ctrl_if #(.REFDIV_W(8), .FBDIV_W(12), .PD1_W(4), .PD2_W(2)) cfg_bus ();

  tc_pll_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_CNT_END (20'd10),
    .USE_LKDT     (1'b1),
    .DEF_BP       (1'b0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .cfg            (cfg_bus.slave),
    .lkdt_i         (lkdt_i),
    .pll_rst_o      (pll_rst_o),
    .pll_refdiv_o   (pll_refdiv_o),
    .pll_fbdiv_o    (pll_fbdiv_o),
    .pll_postdiv1_o (pll_postdiv1_o),
    .pll_postdiv2_o (pll_postdiv2_o),
    .pll_bp_o       (pll_bp_o),
    .lock_o         (lock_o),
    .state_o        (state_o),
    .relock_cnt_o   (relock_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk(input logic rst, input logic lk, input logic rdy,
                              input logic [1:0] st, input logic [7:0] rc,
                              input cfg_t c);
    obs_t o;
    o.rst  = rst;
    o.lock = lk;
    o.rdy  = rdy;
    o.st   = st;
    o.rc   = rc;
    o.cfg  = c;
    return o;
  endfunction

  task automatic exp_snap(input int c, input string nm, input obs_t v);
    snap_t s;
    s.cyc = c;
    s.nm  = nm;
    s.v   = v;
    snap_q.push_back(s);
  endtask

  task automatic exp_edge(input int c, input logic v);
    edge_t e;
    e.cyc = c;
    e.val = v;
    edge_q.push_back(e);
  endtask

  task automatic drive_cfg(input cfg_t c);
    cfg_bus.cfg_refdiv   = c.rd;
    cfg_bus.cfg_fbdiv    = c.fb;
    cfg_bus.cfg_postdiv1 = c.p1;
    cfg_bus.cfg_postdiv2 = c.p2;
    cfg_bus.cfg_bp       = c.bp;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic prev_lock = 1'b0;

  always @(negedge clk) begin
    obs_t  got;
    edge_t e;
    got = mk(pll_rst_o, lock_o, cfg_bus.cfg_ready, state_o, relock_cnt_o,
             '{rd: pll_refdiv_o, fb: pll_fbdiv_o, p1: pll_postdiv1_o,
               p2: pll_postdiv2_o, bp: pll_bp_o});

    for (int i = snap_q.size() - 1; i >= 0; i--) begin
      if (snap_q[i].cyc == cyc) begin
        checks++;
        if (got !== snap_q[i].v) begin
          errors++;
          $display("FAIL %s cyc %0d: got %h required %h (rst,lock,rdy,st,rc,rd,fb,p1,p2,bp)",
                   snap_q[i].nm, cyc, got, snap_q[i].v);
        end
        snap_q.delete(i);
      end else if (snap_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale: required at cyc %0d, now %0d", snap_q[i].nm, snap_q[i].cyc, cyc);
        snap_q.delete(i);
      end
    end

    if (lock_o !== prev_lock) begin
      checks++;
      if (edge_q.size() == 0) begin
        errors++;
        $display("FAIL lock_edge unexpected: lock_o=%b at cyc %0d, none required", lock_o, cyc);
      end else begin
        e = edge_q.pop_front();
        if ((e.cyc != cyc) || (e.val !== lock_o)) begin
          errors++;
          $display("FAIL lock_edge: got lock_o=%b at cyc %0d, required %b at cyc %0d",
                   lock_o, cyc, e.val, e.cyc);
        end
      end
      prev_lock = lock_o;
    end

    if (drain) begin
      drain = 1'b0;
      foreach (snap_q[i]) begin
        checks++;
        errors++;
        $display("FAIL %s never compared (cyc %0d)", snap_q[i].nm, snap_q[i].cyc);
      end
      foreach (edge_q[i]) begin
        checks++;
        errors++;
        $display("FAIL lock_edge missing: required %b at cyc %0d", edge_q[i].val, edge_q[i].cyc);
      end
      snap_q.delete();
      edge_q.delete();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t0;
    int e;
    logic [7:0] rc;

    rst_i             = 1'b0;
    lkdt_i            = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    drive_cfg(DEF_CFG);
    #2 rst_i = 1'b1;

    // Power-on reset, then lock with lkdt_i held high.
    tick(3);
    exp_snap(cyc, "reset_vals", mk(1, 0, 0, S_HOLD, 8'd0, DEF_CFG));
    tick(1);
    rst_i = 1'b0;
    t0 = cyc;
    exp_snap(t0 + 3,  "hold_last",  mk(1, 0, 0, S_HOLD, 8'd0, DEF_CFG));
    exp_snap(t0 + 4,  "wait_entry", mk(0, 0, 0, S_WAIT, 8'd0, DEF_CFG));
    exp_snap(t0 + 14, "wait_last",  mk(0, 0, 0, S_WAIT, 8'd0, DEF_CFG));
    exp_snap(t0 + 15, "first_lock", mk(0, 1, 1, S_LOCK, 8'd0, DEF_CFG));
    exp_edge(t0 + 15, 1'b1);
    tick(20);

    // 300 one-cycle lock-loss pulses; relock count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      e  = cyc;
      rc = (i >= 254) ? 8'd255 : 8'(i + 1);
      lkdt_i = 1'b0;
      exp_edge(e + 3, 1'b0);
      exp_edge(e + 18, 1'b1);
      exp_snap(e + 3,  "loss_hold", mk(1, 0, 0, S_HOLD, rc, DEF_CFG));
      exp_snap(e + 18, "relock",    mk(0, 1, 1, S_LOCK, rc, DEF_CFG));
      tick(1);
      lkdt_i = 1'b1;
      tick(19);
    end

    // Accept a configuration in LOCK; hold valid (with other data) through WAIT.
    e = cyc;
    drive_cfg(D_CFG);
    cfg_bus.cfg_valid = 1'b1;
    exp_edge(e + 1, 1'b0);
    exp_snap(e + 1,  "accept_edge",  mk(1, 0, 0, S_HOLD, 8'd255, D_CFG));
    exp_snap(e + 5,  "no_reaccept1", mk(0, 0, 0, S_WAIT, 8'd255, D_CFG));
    exp_snap(e + 15, "no_reaccept2", mk(0, 0, 0, S_WAIT, 8'd255, D_CFG));
    exp_snap(e + 16, "cfg_relock",   mk(0, 1, 1, S_LOCK, 8'd255, D_CFG));
    exp_edge(e + 16, 1'b1);
    tick(1);
    drive_cfg(DECOY);
    tick(14);
    cfg_bus.cfg_valid = 1'b0;
    tick(3);

    // Accept a bypass configuration; lkdt_i toggles in BYP without effect.
    e = cyc;
    drive_cfg(E_CFG);
    cfg_bus.cfg_valid = 1'b1;
    exp_edge(e + 1, 1'b0);
    exp_snap(e + 1,  "byp_hold0", mk(1, 0, 0, S_HOLD, 8'd255, E_CFG));
    exp_snap(e + 4,  "byp_hold3", mk(1, 0, 0, S_HOLD, 8'd255, E_CFG));
    exp_snap(e + 5,  "byp_entry", mk(1, 1, 1, S_BYP,  8'd255, E_CFG));
    exp_edge(e + 5, 1'b1);
    tick(1);
    cfg_bus.cfg_valid = 1'b0;
    tick(5);
    lkdt_i = 1'b0;
    tick(2);
    lkdt_i = 1'b1;
    tick(1);
    lkdt_i = 1'b0;
    tick(3);
    lkdt_i = 1'b1;
    exp_snap(e + 14, "byp_ignore_lkdt1", mk(1, 1, 1, S_BYP, 8'd255, E_CFG));
    exp_snap(e + 20, "byp_ignore_lkdt2", mk(1, 1, 1, S_BYP, 8'd255, E_CFG));
    tick(9);

    // Leave bypass, then hit reset in the middle of WAIT.
    e = cyc;
    drive_cfg(F_CFG);
    cfg_bus.cfg_valid = 1'b1;
    exp_edge(e + 1, 1'b0);
    exp_snap(e + 1, "byp_exit_hold", mk(1, 0, 0, S_HOLD, 8'd255, F_CFG));
    exp_snap(e + 5, "byp_exit_wait", mk(0, 0, 0, S_WAIT, 8'd255, F_CFG));
    tick(1);
    cfg_bus.cfg_valid = 1'b0;
    tick(8);
    rst_i  = 1'b1;
    lkdt_i = 1'b0;
    exp_snap(e + 9,  "mid_wait_reset", mk(1, 0, 0, S_HOLD, 8'd0, DEF_CFG));
    exp_snap(e + 12, "reset_held",     mk(1, 0, 0, S_HOLD, 8'd0, DEF_CFG));
    tick(5);

    // Release with lkdt_i low until edge 40: WAIT persists until it rises.
    rst_i = 1'b0;
    t0 = cyc;
    exp_snap(t0 + 4,  "lkdt_wait_entry", mk(0, 0, 0, S_WAIT, 8'd0, DEF_CFG));
    exp_snap(t0 + 15, "lkdt_wait_15",    mk(0, 0, 0, S_WAIT, 8'd0, DEF_CFG));
    exp_snap(t0 + 30, "lkdt_wait_30",    mk(0, 0, 0, S_WAIT, 8'd0, DEF_CFG));
    exp_snap(t0 + 42, "lkdt_wait_42",    mk(0, 0, 0, S_WAIT, 8'd0, DEF_CFG));
    exp_snap(t0 + 43, "lkdt_lock",       mk(0, 1, 1, S_LOCK, 8'd0, DEF_CFG));
    exp_edge(t0 + 43, 1'b1);
    tick(40);
    lkdt_i = 1'b1;
    tick(6);

    drain = 1'b1;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
